// File: rtl/mnist_infer_scheduler.sv
// Batch inference sequencer: sample fetch, vote reduction, argmax and result stream for a cke-gated LUT network.
// Optional accuracy counters are built when MNIST_INFER_SCHEDULER_ACCURACY_EN is defined.
module mnist_infer_scheduler #(
    parameter int USER_WIDTH  = 8,
    parameter int INPUT_WIDTH = 784,
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 1,
    parameter int ADDR_WIDTH  = 14,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                              reset,
    input  logic                              clk,
    input  logic                              cke,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             start_addr,
    input  logic [COUNT_WIDTH-1:0]            num,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [USER_WIDTH+INPUT_WIDTH-1:0] mem_rdata,
    output logic                              net_cke,
    output logic [USER_WIDTH:0]               net_in_user,
    output logic [INPUT_WIDTH-1:0]            net_in_data,
    output logic                              net_in_valid,
    input  logic [USER_WIDTH:0]               net_out_user,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0]  net_out_data,
    input  logic                              net_out_valid,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [$clog2(CLASS_NUM+1)-1:0]    res_class,
    output logic [USER_WIDTH-1:0]             res_label,
    output logic                              res_match,
    output logic                              res_last,
    output logic [COUNT_WIDTH-1:0]            total_count,
    output logic [COUNT_WIDTH-1:0]            ok_count,
    output logic [1:0]                        dbg_state_o
);
    localparam int CW = $clog2(CLASS_NUM+1);
    localparam int VW = $clog2(CHANNEL_NUM+1);
    localparam int MW = CW + USER_WIDTH;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_last_q, rd_last_d;
    logic                   done_q, done_d;
    logic                   en;

    logic                   s_valid_q, s_last_q;
    logic [USER_WIDTH-1:0]  s_label_q;
    logic [VW-1:0]          vote_q [CLASS_NUM];
    logic [VW-1:0]          vote_d [CLASS_NUM];
    logic [CW-1:0]          best_cls;
    logic [VW-1:0]          best_v;
    logic                   match_d;

    logic                   res_valid_q, res_last_q, res_match_q;
    logic [CW-1:0]          res_class_q;
    logic [USER_WIDTH-1:0]  res_label_q;

    // Result stream: a result transfers on a clock where res_valid & res_ready (and cke);
    // while res_valid is high without res_ready everything, including the network, holds.
    assign en = cke & (~res_valid_q | res_ready);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        mem_en     = 1'b0;
        case (state_q)
            IDLE: begin
                rd_valid_d = 1'b0;
                if (start) begin
                    if (num != '0) begin
                        addr_d  = start_addr;
                        rem_d   = num;
                        state_d = FEED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FEED: begin
                mem_en     = en;
                addr_d     = addr_q + ADDR_WIDTH'(1);
                rem_d      = rem_q - COUNT_WIDTH'(1);
                rd_valid_d = 1'b1;
                rd_last_d  = (rem_q == COUNT_WIDTH'(1));
                if (rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                rd_valid_d = 1'b0;
                if (res_valid_q & res_ready & res_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= en & done_d;
            if (en) begin
                state_q    <= state_d;
                addr_q     <= addr_d;
                rem_q      <= rem_d;
                rd_valid_q <= rd_valid_d;
                rd_last_q  <= rd_last_d;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CLASS_NUM; i++) begin
            vote_d[i] = '0;
            for (int j = 0; j < CHANNEL_NUM; j++)
                vote_d[i] = vote_d[i] + VW'(net_out_data[j*CLASS_NUM+i]);
        end
    end

    // Strict greater-than keeps the lowest index on ties; no votes leaves the all-ones code.
    always_comb begin
        best_cls = '1;
        best_v   = '0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (vote_q[i] > best_v) begin
                best_v   = vote_q[i];
                best_cls = CW'(i);
            end
        end
        match_d = s_valid_q && (best_v != '0) && (MW'(best_cls) == MW'(s_label_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid_q   <= 1'b0;
            s_last_q    <= 1'b0;
            s_label_q   <= '0;
            vote_q      <= '{default: '0};
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_match_q <= 1'b0;
            res_class_q <= '0;
            res_label_q <= '0;
        end else if (en) begin
            s_valid_q   <= net_out_valid;
            s_last_q    <= net_out_valid & net_out_user[USER_WIDTH];
            s_label_q   <= net_out_user[USER_WIDTH-1:0];
            vote_q      <= vote_d;
            res_valid_q <= s_valid_q;
            res_last_q  <= s_last_q;
            res_match_q <= match_d;
            res_class_q <= best_cls;
            res_label_q <= s_label_q;
        end
    end

`ifdef MNIST_INFER_SCHEDULER_ACCURACY_EN
    logic [COUNT_WIDTH-1:0] total_q, ok_q;
    logic                   clr_cnt;

    assign clr_cnt = (state_q == IDLE) & start;

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            ok_q    <= '0;
        end else if (en) begin
            if (clr_cnt) begin
                total_q <= '0;
                ok_q    <= '0;
            end else if (res_valid_q) begin
                if (total_q != '1) total_q <= total_q + COUNT_WIDTH'(1);
                if (res_match_q && ok_q != '1) ok_q <= ok_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign total_count = total_q;
    assign ok_count    = ok_q;
`else
    assign total_count = '0;
    assign ok_count    = '0;
`endif

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign mem_addr     = addr_q;
    assign net_cke      = en;
    assign net_in_valid = rd_valid_q;
    assign net_in_user  = {rd_last_q, mem_rdata[USER_WIDTH+INPUT_WIDTH-1:INPUT_WIDTH]};
    assign net_in_data  = mem_rdata[INPUT_WIDTH-1:0];
    assign res_valid    = res_valid_q;
    assign res_class    = res_class_q;
    assign res_label    = res_label_q;
    assign res_match    = res_match_q;
    assign res_last     = res_last_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mnist_infer_scheduler.sv
// Bench for mnist_infer_scheduler: memory model, 1-cycle network stand-in, batch table and corner sequences.
module tb_mnist_infer_scheduler;
    localparam int UW = 8, IW = 784, CN = 10, AW = 14, NW = 32, CW = 4;

`ifdef MNIST_INFER_SCHEDULER_ACCURACY_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, cke = 1'b1, start = 1'b0, res_ready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [NW-1:0] num = '0;
    logic busy, done, mem_en, net_cke, net_in_valid, res_valid, res_match, res_last;
    logic [AW-1:0] mem_addr;
    logic [UW+IW-1:0] mem_rdata = '0;
    logic [UW:0] net_in_user, net_out_user = '0;
    logic [IW-1:0] net_in_data;
    logic [CN-1:0] net_out_data = '0;
    logic net_out_valid = 1'b0;
    logic [CW-1:0] res_class;
    logic [UW-1:0] res_label;
    logic [NW-1:0] total_count, ok_count;
    logic [1:0] dbg_state;

    mnist_infer_scheduler dut (
        .reset(reset), .clk(clk), .cke(cke), .start(start), .start_addr(start_addr), .num(num),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .net_cke(net_cke), .net_in_user(net_in_user), .net_in_data(net_in_data),
        .net_in_valid(net_in_valid), .net_out_user(net_out_user), .net_out_data(net_out_data),
        .net_out_valid(net_out_valid), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_label(res_label), .res_match(res_match), .res_last(res_last),
        .total_count(total_count), .ok_count(ok_count), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [8:0]    pix;
        logic [7:0]    label;
        logic [3:0]    cls;
        logic          match;
    } samp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int num;
        int idx;
        int stall_at;
        int stall_len;
        bit dbl;
        int total;
        int ok;
    } batch_t;

    samp_t  samp [13];
    batch_t btab [5];

    logic [8:0]    pix_mem [0:(1<<AW)-1];
    logic [UW-1:0] lab_mem [0:(1<<AW)-1];

    logic [13:0]   exp_q [$];
    logic [AW-1:0] addr_seen [$];
    int n_checks = 0, n_fail = 0;
    int cyc_cnt = 0, last_acc_cyc = -10;
    logic prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // pix[3:0] votes for that class, pix[7:4] adds a second vote when pix[8]; codes >= 10 vote nothing.
    function automatic logic [CN-1:0] votes(input logic [8:0] p);
        logic [CN-1:0] v;
        v = '0;
        if (p[3:0] < 4'd10) v[p[3:0]] = 1'b1;
        if (p[8] && p[7:4] < 4'd10) v[p[7:4]] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_en) mem_rdata <= {lab_mem[mem_addr], {(IW-9){1'b0}}, pix_mem[mem_addr]};
        if (reset) begin
            net_out_valid <= 1'b0;
            net_out_user  <= '0;
            net_out_data  <= '0;
        end else if (net_cke) begin
            net_out_valid <= net_in_valid;
            net_out_user  <= net_in_user;
            net_out_data  <= votes(net_in_data[8:0]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and stall monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en) addr_seen.push_back(mem_addr);
            if (res_valid && !res_ready && cke) begin
                check("stall_net_cke", 64'(net_cke), 64'd0);
                check("stall_mem_en", 64'(mem_en), 64'd0);
                if (prev_stall) check("stall_addr_frozen", 64'(mem_addr), 64'(prev_addr));
            end
            prev_stall <= res_valid && !res_ready && cke;
            prev_addr  <= mem_addr;
            if (res_valid && res_ready && cke) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got class %0d label %0d with empty queue", res_class, res_label);
                end else begin
                    check("result{class,label,match,last}", 64'({res_class, res_label, res_match, res_last}),
                          64'(exp_q.pop_front()));
                    if (res_last) last_acc_cyc <= cyc_cnt;
                end
            end
        end
    end

    task automatic run_batch(input int b);
        batch_t r;
        samp_t s;
        bit done_seen;
        logic [AW-1:0] ea;
        r = btab[b];
        addr_seen.delete();
        for (int k = 0; k < r.num; k++) begin
            s = samp[r.idx+k];
            exp_q.push_back({s.cls, s.label, s.match, (k == r.num-1)});
        end
        @(posedge clk); #1;
        start_addr = r.addr; num = NW'(r.num); start = 1'b1;
        @(posedge clk); #1;
        if (r.dbl) begin
            start_addr = AW'(500); num = NW'(7);
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        check("first_mem_en", 64'(mem_en), 64'd1);
        check("first_mem_addr", 64'(mem_addr), 64'(r.addr));
        check("busy_in_batch", 64'(busy), 64'd1);
        if (r.dbl) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        done_seen = 1'b0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            @(posedge clk); #1;
            res_ready = !(c >= r.stall_at && c < r.stall_at + r.stall_len);
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        res_ready = 1'b1;
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: batch %0d no done within 300 cycles", b);
        end else begin
            check("done_after_last_accept", 64'(cyc_cnt), 64'(last_acc_cyc + 1));
            check("busy_at_done", 64'(busy), 64'd0);
            check("total_count", 64'(total_count), ACC_EN ? 64'(r.total) : 64'd0);
            check("ok_count", 64'(ok_count), ACC_EN ? 64'(r.ok) : 64'd0);
            check("results_drained", 64'(exp_q.size()), 64'd0);
            check("addr_count", 64'(addr_seen.size()), 64'(r.num));
            for (int k = 0; k < r.num && k < addr_seen.size(); k++) begin
                ea = r.addr + AW'(k);
                check("addr_seq", 64'(addr_seen[k]), 64'(ea));
            end
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("no_restart", 64'(busy), 64'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        samp[0]  = '{14'd100,   9'h003, 8'd3,  4'd3,  1'b1};
        samp[1]  = '{14'd101,   9'h007, 8'd7,  4'd7,  1'b1};
        samp[2]  = '{14'd102,   9'h001, 8'd2,  4'd1,  1'b0};
        samp[3]  = '{14'd200,   9'h152, 8'd5,  4'd2,  1'b0};
        samp[4]  = '{14'd201,   9'h00F, 8'd15, 4'd15, 1'b0};
        samp[5]  = '{14'd16383, 9'h009, 8'd9,  4'd9,  1'b1};
        samp[6]  = '{14'd0,     9'h000, 8'd4,  4'd0,  1'b0};
        samp[7]  = '{14'd300,   9'h004, 8'd4,  4'd4,  1'b1};
        samp[8]  = '{14'd301,   9'h165, 8'd6,  4'd5,  1'b0};
        samp[9]  = '{14'd302,   9'h00A, 8'd0,  4'd15, 1'b0};
        samp[10] = '{14'd303,   9'h180, 8'd0,  4'd0,  1'b1};
        samp[11] = '{14'd304,   9'h008, 8'd8,  4'd8,  1'b1};
        samp[12] = '{14'd305,   9'h002, 8'd2,  4'd2,  1'b1};
        //            addr        num idx stall_at len  dbl  total ok
        btab[0] = '{14'd100,   3, 0,  1000, 0, 1'b0, 3, 2};
        btab[1] = '{14'd100,   3, 0,  4,    5, 1'b0, 3, 2};
        btab[2] = '{14'd200,   2, 3,  1000, 0, 1'b0, 2, 0};
        btab[3] = '{14'd16383, 2, 5,  1000, 0, 1'b1, 2, 1};
        btab[4] = '{14'd300,   6, 7,  3,    5, 1'b0, 6, 4};
        for (int i = 0; i < (1<<AW); i++) begin
            pix_mem[i] = 9'h00F;
            lab_mem[i] = '0;
        end
        for (int i = 0; i < 13; i++) begin
            pix_mem[samp[i].addr] = samp[i].pix;
            lab_mem[samp[i].addr] = samp[i].label;
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_flags", 64'({busy, done, mem_en, net_in_valid, res_valid, res_last, res_match}), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_total", 64'(total_count), 64'd0);
        check("reset_ok", 64'(ok_count), 64'd0);

        for (int b = 0; b < 5; b++) run_batch(b);

        // start with cke low is frozen; then num == 0 gives done only.
        @(posedge clk); #1;
        cke = 1'b0; num = '0; start = 1'b1;
        @(posedge clk); #1;
        cke = 1'b1; start = 1'b0;
        @(negedge clk);
        check("cke0_no_done", 64'(done), 64'd0);
        check("cke0_no_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("num0_done", 64'(done), 64'd1);
        check("num0_busy", 64'(busy), 64'd0);
        check("num0_mem_en", 64'(mem_en), 64'd0);
        check("num0_total_clr", 64'(total_count), 64'd0);
        check("num0_ok_clr", 64'(ok_count), 64'd0);
        @(negedge clk);
        check("num0_done_pulse", 64'(done), 64'd0);
        check("num0_busy_after", 64'(busy), 64'd0);

        // Reset in the middle of FEED.
        @(posedge clk); #1;
        start_addr = AW'(300); num = NW'(6); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_res_valid", 64'(res_valid), 64'd0);
        check("midreset_net_in_valid", 64'(net_in_valid), 64'd0);
        check("midreset_mem_en", 64'(mem_en), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        run_batch(4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mnist_infer_scheduler.md
Name: mnist_infer_scheduler

Overview:
- Sequences batch inference through a fixed-latency, cke-gated MNIST LUT network (for example a 1-cycle-latency stand-in, or a MnistLut4Simple instance with USER_WIDTH = 1+USER_WIDTH).
- Fetches START_ADDR..START_ADDR+NUM-1 from a sample memory and drives the network input with a last tag.
- Reduces the network's per-channel class votes, computes the argmax, and presents per-sample results on a valid/ready stream.
- Keeps accuracy counters and stalls the whole pipeline via net_cke when the result consumer backpressures.

Parameters:
- USER_WIDTH, 8, label width carried with each sample.
- INPUT_WIDTH, 784, binary pixel vector width.
- CLASS_NUM, 10, number of classes.
- CHANNEL_NUM, 1, spatial channel multiplicity of the network output.
- ADDR_WIDTH, 14, sample memory address width.
- COUNT_WIDTH, 32, width of NUM and of both counters.

Ports:
- reset  in  1  synchronous, active-high
- clk  in  1  single clock
- cke  in  1  global clock enable
- start  in  1  one-cycle start request
- start_addr  in  ADDR_WIDTH  first sample address
- num  in  COUNT_WIDTH  sample count
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at batch end
- mem_en  out  1  read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  USER_WIDTH+INPUT_WIDTH  {label, pixels}; valid one clk after mem_en and held while mem_en=0
- net_cke  out  1  network clock enable
- net_in_user  out  1+USER_WIDTH  {last, label}
- net_in_data  out  INPUT_WIDTH  pixels
- net_in_valid  out  1  input valid
- net_out_user  in  1+USER_WIDTH  {last, label} from network
- net_out_data  in  CLASS_NUM*CHANNEL_NUM  votes; bit j*CLASS_NUM+i is channel j, class i
- net_out_valid  in  1  network output valid
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- res_class  out  $clog2(CLASS_NUM+1)  argmax class
- res_label  out  USER_WIDTH  label
- res_match  out  1  res_class == res_label
- res_last  out  1  final sample of batch
- total_count  out  COUNT_WIDTH  results accepted
- ok_count  out  COUNT_WIDTH  matched results accepted

Behaviour:
- Stall signal: en = cke & (!res_valid | res_ready). net_cke = en. Every internal register, including the FSM, address and remaining counters, advances only when en=1.
- Reset: state=IDLE. busy, done, mem_en, net_in_valid, res_valid, res_last, res_match, total_count and ok_count are all 0. mem_addr=0. In-flight samples are discarded. The network must share the same reset.
- FSM IDLE:
  - start & num!=0: latch addr=start_addr and rem=num, clear both counters, go to FEED.
  - start & num==0: clear both counters, pulse done next cycle, stay IDLE.
- FSM FEED:
  - mem_en = en, mem_addr = addr.
  - On each en cycle: addr+1, rem-1, rd_valid<=1, rd_last<=(rem==1).
  - When rem==1, go to DRAIN.
  - start is ignored while busy.
- FSM DRAIN:
  - mem_en=0. On en cycles rd_valid<=0.
  - On the accepted result with res_last=1 (res_valid & res_ready): pulse done, go to IDLE.
- Address wrap: mem_addr wraps modulo 2^ADDR_WIDTH.
- Network input:
  - net_in_valid = rd_valid.
  - net_in_user = {rd_last, mem_rdata[USER_WIDTH+INPUT_WIDTH-1:INPUT_WIDTH]}.
  - net_in_data = mem_rdata[INPUT_WIDTH-1:0].
- Sum stage (registered, advances on en):
  - vote[i] = sum over j of net_out_data[j*CLASS_NUM+i], width $clog2(CHANNEL_NUM+1).
  - valid, last and label are registered alongside.
- Result stage (registered, advances on en):
  - res_class = argmax of vote under strict greater-than; the lowest index wins ties.
  - If all votes are 0, res_class = all-ones and res_match = 0.
  - res_valid, res_last and res_label follow the sum stage.
- Latency: start to first mem_en is 1 cycle. Network output to res_valid is 2 en cycles.
- Counters update on each accepted result (res_valid & res_ready): total+1, ok+res_match. Both saturate at all-ones.
- cke=0: all state is frozen, and done is not generated.

Optional Feature:
- Macro MNIST_INFER_SCHEDULER_ACCURACY_EN.
- Defined: total_count and ok_count behave as specified above.
- Undefined: both counters are tied to 0, res_match is still produced, and the counter logic is removed.

Test Plan:
- Batch of 3 samples; memory labels/votes give classes 3,7,1 vs labels 3,7,2; res_ready=1 -> 3 results, res_last only on the third, total=3, ok=2, done pulses 1 cycle after the third acceptance.
- Same batch with res_ready held low for 5 cycles mid-batch -> net_cke=0 and mem_addr frozen for those cycles; results equal the unstalled run in value and order.
- start with num=0 -> done one cycle later, busy stays 0, mem_en never asserted, counters cleared.
- Votes for classes 2 and 5 both 1 with CHANNEL_NUM=1 -> res_class=2. All votes 0 -> res_class=15 (4-bit), res_match=0.
- start_addr=2^ADDR_WIDTH-1, num=2 -> addresses 16383 then 0. start pulsed during FEED is ignored.
- reset asserted mid-FEED -> next cycle busy=0, res_valid=0, net_in_valid=0; a fresh start runs a correct batch.
